// File: rtl/seven_seg_capture_pkg.sv
// rtl/seven_seg_capture_pkg.sv - shared symbol codes, segment patterns and capture FSM states
package seven_seg_capture_pkg;

    localparam int AN_W  = 4;
    localparam int SEG_W = 7;
    localparam int SYM_W = 5;

    localparam logic [SYM_W-1:0] SYM_DASH  = 5'h10;
    localparam logic [SYM_W-1:0] SYM_BLANK = 5'h11;
    localparam logic [SYM_W-1:0] SYM_UNK   = 5'h1F;

    // Active-low cathodes, bit 6 = segment a ... bit 0 = segment g
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURED
    } cap_state_e;

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0:    hex_to_seg = 7'b0000001;
            4'h1:    hex_to_seg = 7'b1001111;
            4'h2:    hex_to_seg = 7'b0010010;
            4'h3:    hex_to_seg = 7'b0000110;
            4'h4:    hex_to_seg = 7'b1001100;
            4'h5:    hex_to_seg = 7'b0100100;
            4'h6:    hex_to_seg = 7'b0100000;
            4'h7:    hex_to_seg = 7'b0001111;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0000100;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b1100000;
            4'hC:    hex_to_seg = 7'b0110001;
            4'hD:    hex_to_seg = 7'b1000010;
            4'hE:    hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_capture_if.sv
// rtl/seven_seg_capture_if.sv - multiplexed seven-segment bus (anodes + cathodes, active-low)
interface seven_seg_capture_if;
    import seven_seg_capture_pkg::*;

    logic [AN_W-1:0]  an;
    logic [SEG_W-1:0] seg;

    modport master (output an, seg);
    modport slave  (input  an, seg);
endinterface

// File: rtl/seven_seg_capture_decode.sv
// rtl/seven_seg_capture_decode.sv - combinational cathode pattern to 5-bit symbol decoder
module seg_pattern_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic [SYM_W-1:0] o_sym
);
    always_comb begin
        o_sym = SYM_UNK;
        if (i_seg == SEG_DASH)
            o_sym = SYM_DASH;
        else if (i_seg == SEG_BLANK)
            o_sym = SYM_BLANK;
        for (int i = 0; i < 16; i++)
            if (i_seg == hex_to_seg(4'(i)))
                o_sym = SYM_W'(i);
    end
endmodule

// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - seven-segment bus monitor: synchronize, debounce, decode, reassemble frames
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    seven_seg_capture_if.slave   bus,
    output logic [4*SYM_W-1:0]   o_digits,
    output logic                 o_frame_valid,
    output logic [5:0]           o_result,
    output logic                 o_result_ok,
    output logic                 o_invalid,
    output logic                 o_stall,
    output logic                 o_bad_an
);
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_MAX     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [4*SYM_W-1:0] FRAME_E404  = {5'h0E, 5'h04, 5'h00, 5'h04};

    logic [AN_W-1:0]  r_an_s1, r_an_s2, r_ref_an;
    logic [SEG_W-1:0] r_seg_s1, r_seg_s2, r_ref_seg;
    cap_state_e       r_state;
    logic [CNT_W-1:0] r_settle, r_timeout;
    logic             r_multi_prev;
    logic [AN_W-1:0]  r_mask;
    logic [SYM_W-1:0] r_shadow [AN_W];

    logic [2:0]         w_low_cnt;
    logic               w_one_low, w_multi_low, w_an_idle, w_changed, w_write, w_tmo_hit, w_ok;
    logic [1:0]         w_slot;
    logic [SYM_W-1:0]   w_sym;
    logic [4*SYM_W-1:0] w_frame;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an_s1  <= '1;
            r_an_s2  <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
        end else begin
            r_an_s1  <= bus.an;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= bus.seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_low_cnt   = 3'($countones(~r_an_s2));
    assign w_one_low   = (w_low_cnt == 3'd1);
    assign w_multi_low = (w_low_cnt >= 3'd2);
    assign w_an_idle   = (r_an_s2 == '1);
    assign w_changed   = ({r_an_s2, r_seg_s2} != {r_ref_an, r_ref_seg});
    assign w_write     = (r_state == ST_SETTLE) && !w_changed && (r_settle == SETTLE_LAST);
    assign w_tmo_hit   = (r_timeout == TMO_MAX - CNT_W'(1));

    always_comb begin
        w_slot = 2'd0;
        for (int i = 0; i < AN_W; i++)
            if (!r_ref_an[i])
                w_slot = 2'(i);
    end

    seg_pattern_decode u_decode (
        .i_seg (r_ref_seg),
        .o_sym (w_sym)
    );

    // Settle count starts at 0 on the first cycle the new pair is seen, so the write lands STABLE_CYCLES after sync
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_settle     <= '0;
            r_ref_an     <= '1;
            r_ref_seg    <= '1;
            r_multi_prev <= 1'b0;
            o_bad_an     <= 1'b0;
        end else begin
            r_multi_prev <= w_multi_low;
            o_bad_an     <= w_multi_low && !r_multi_prev;
            case (r_state)
                ST_IDLE: begin
                    if (w_one_low) begin
                        r_state   <= ST_SETTLE;
                        r_ref_an  <= r_an_s2;
                        r_ref_seg <= r_seg_s2;
                        r_settle  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_multi_low || w_an_idle) begin
                        r_state  <= ST_IDLE;
                        r_settle <= '0;
                    end else if (w_changed) begin
                        r_ref_an  <= r_an_s2;
                        r_ref_seg <= r_seg_s2;
                        r_settle  <= '0;
                    end else if (w_write) begin
                        r_state <= ST_CAPTURED;
                    end else begin
                        r_settle <= r_settle + CNT_W'(1);
                    end
                end
                ST_CAPTURED: begin
                    if (w_multi_low || w_an_idle) begin
                        r_state <= ST_IDLE;
                    end else if (w_changed) begin
                        r_state   <= ST_SETTLE;
                        r_ref_an  <= r_an_s2;
                        r_ref_seg <= r_seg_s2;
                        r_settle  <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_frame = {r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
    assign w_ok    = (w_frame[19:15] == SYM_DASH) && (w_frame[14:10] == SYM_DASH)
                   && (w_frame[9:5] <= 5'h03) && (w_frame[4:0] <= 5'h0F);

    // A slot write beats a coinciding timeout: counter clears and the mask survives
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < AN_W; i++)
                r_shadow[i] <= '0;
            r_mask        <= '0;
            r_timeout     <= '0;
            o_stall       <= 1'b0;
            o_frame_valid <= 1'b0;
            o_digits      <= '0;
            o_result      <= '0;
            o_result_ok   <= 1'b0;
            o_invalid     <= 1'b0;
        end else begin
            if (w_write)
                r_shadow[w_slot] <= w_sym;

            if (w_write)
                r_mask <= ((r_mask == 4'hF) ? 4'h0 : r_mask) | (4'b0001 << w_slot);
            else if ((r_mask == 4'hF) || w_tmo_hit)
                r_mask <= 4'h0;

            if (w_write) begin
                r_timeout <= '0;
                o_stall   <= 1'b0;
            end else if (r_timeout != TMO_MAX) begin
                r_timeout <= r_timeout + CNT_W'(1);
                if (w_tmo_hit)
                    o_stall <= 1'b1;
            end

            o_frame_valid <= (r_mask == 4'hF);
            if (r_mask == 4'hF) begin
                o_digits    <= w_frame;
                o_result    <= {w_frame[6:5], w_frame[3:0]};
                o_result_ok <= w_ok;
                o_invalid   <= (w_frame == FRAME_E404);
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed self-checking bench for seven_seg_capture
module tb_seven_seg_capture;
    localparam int STABLE  = 16;
    localparam int TIMEOUT = 3000;
    localparam int DWELL   = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [19:0] digits;
    logic        frame_valid, result_ok, invalid, stall, bad_an;
    logic [5:0]  result;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;
    int bad_cnt = 0;
    int d0_08_cnt = 0;

    seven_seg_capture_if bus ();

    seven_seg_capture #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (20)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .bus           (bus),
        .o_digits      (digits),
        .o_frame_valid (frame_valid),
        .o_result      (result),
        .o_result_ok   (result_ok),
        .o_invalid     (invalid),
        .o_stall       (stall),
        .o_bad_an      (bad_an)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (bad_an) bad_cnt++;
        if (digits[4:0] == 5'h08) d0_08_cnt++;
    end

    function automatic logic [6:0] pat(input logic [4:0] s);
        case (s)
            5'h00: pat = 7'b0000001;
            5'h02: pat = 7'b0010010;
            5'h03: pat = 7'b0000110;
            5'h04: pat = 7'b1001100;
            5'h0A: pat = 7'b0001000;
            5'h0B: pat = 7'b1100000;
            5'h0E: pat = 7'b0110000;
            5'h10: pat = 7'b1111110;
            default: pat = 7'b1111111;
        endcase
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an  = an;
        bus.seg = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input int idx, input logic [4:0] sym, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << idx);
        drive(an, pat(sym), n);
    endtask

    task automatic scan_frame(input logic [4:0] s3, s2, s1, s0);
        digit(0, s0, DWELL);
        digit(1, s1, DWELL);
        digit(2, s2, DWELL);
        digit(3, s3, DWELL);
    endtask

    task automatic test_reset;
        bus.an = 4'hF; bus.seg = 7'h7F;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (digits !== 20'h0) begin failures++; $display("FAIL reset_digits: got %h expected 00000", digits); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
        checks++; if (result !== 6'h0) begin failures++; $display("FAIL reset_result: got %h expected 00", result); end
        checks++; if (result_ok !== 1'b0) begin failures++; $display("FAIL reset_result_ok: got %b expected 0", result_ok); end
        checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid: got %b expected 0", invalid); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (bad_an !== 1'b0) begin failures++; $display("FAIL reset_bad_an: got %b expected 0", bad_an); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_dash_2b;
        int fv0;
        fv0 = fv_cnt;
        scan_frame(5'h10, 5'h10, 5'h02, 5'h0B);
        scan_frame(5'h10, 5'h10, 5'h02, 5'h0B);
        checks++; if (fv_cnt - fv0 != 2) begin failures++; $display("FAIL dash2b_frames: got %0d expected 2", fv_cnt - fv0); end
        checks++; if (digits !== {5'h10, 5'h10, 5'h02, 5'h0B}) begin failures++; $display("FAIL dash2b_digits: got %h expected %h", digits, {5'h10, 5'h10, 5'h02, 5'h0B}); end
        checks++; if (result !== 6'h2B) begin failures++; $display("FAIL dash2b_result: got %h expected 2b", result); end
        checks++; if (result_ok !== 1'b1) begin failures++; $display("FAIL dash2b_result_ok: got %b expected 1", result_ok); end
        checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL dash2b_invalid: got %b expected 0", invalid); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL dash2b_stall: got %b expected 0", stall); end
    endtask

    task automatic test_e404;
        scan_frame(5'h0E, 5'h04, 5'h00, 5'h04);
        checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL e404_invalid: got %b expected 1", invalid); end
        checks++; if (result_ok !== 1'b0) begin failures++; $display("FAIL e404_result_ok: got %b expected 0", result_ok); end
        checks++; if (digits !== {5'h0E, 5'h04, 5'h00, 5'h04}) begin failures++; $display("FAIL e404_digits: got %h expected %h", digits, {5'h0E, 5'h04, 5'h00, 5'h04}); end
        checks++; if (result !== 6'h04) begin failures++; $display("FAIL e404_result: got %h expected 04", result); end
    endtask

    task automatic test_glitch;
        int fv0, g0;
        fv0 = fv_cnt; g0 = d0_08_cnt;
        digit(0, 5'h0B, 50);
        drive(4'b1110, 7'b0000000, 5);
        digit(0, 5'h0B, 45);
        digit(1, 5'h02, DWELL);
        digit(2, 5'h10, DWELL);
        digit(3, 5'h10, DWELL);
        checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL glitch_frames: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (digits[4:0] !== 5'h0B) begin failures++; $display("FAIL glitch_digit0: got %h expected 0b", digits[4:0]); end
        checks++; if (d0_08_cnt != g0) begin failures++; $display("FAIL glitch_no_08: got %0d cycles of 08 expected 0", d0_08_cnt - g0); end
    endtask

    task automatic test_bad_an;
        int fv0, b0;
        fv0 = fv_cnt; b0 = bad_cnt;
        digit(0, 5'h0A, DWELL);
        digit(1, 5'h03, DWELL);
        drive(4'b1100, pat(5'h03), 50);
        digit(2, 5'h10, DWELL);
        digit(3, 5'h10, DWELL);
        checks++; if (bad_cnt - b0 != 1) begin failures++; $display("FAIL bad_an_pulses: got %0d expected 1", bad_cnt - b0); end
        checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL bad_an_frames: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (digits !== {5'h10, 5'h10, 5'h03, 5'h0A}) begin failures++; $display("FAIL bad_an_digits: got %h expected %h", digits, {5'h10, 5'h10, 5'h03, 5'h0A}); end
        checks++; if (result !== 6'h3A) begin failures++; $display("FAIL bad_an_result: got %h expected 3a", result); end
    endtask

    task automatic test_timeout;
        int fv0;
        fv0 = fv_cnt;
        digit(0, 5'h0B, DWELL);
        digit(1, 5'h02, DWELL);
        digit(2, 5'h10, DWELL);
        drive(4'hF, 7'h7F, TIMEOUT - 200);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL timeout_early_stall: got %b expected 0", stall); end
        drive(4'hF, 7'h7F, 210);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL timeout_stall: got %b expected 1", stall); end
        digit(3, 5'h10, DWELL);
        checks++; if (fv_cnt - fv0 != 0) begin failures++; $display("FAIL timeout_partial_frame: got %0d expected 0", fv_cnt - fv0); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL timeout_stall_clear: got %b expected 0", stall); end
        digit(0, 5'h0B, DWELL);
        digit(1, 5'h02, DWELL);
        digit(2, 5'h10, DWELL);
        checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL timeout_resume_frames: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (result !== 6'h2B) begin failures++; $display("FAIL timeout_resume_result: got %h expected 2b", result); end
    endtask

    task automatic test_reset_mid;
        int fv0;
        digit(0, 5'h04, DWELL);
        digit(1, 5'h00, 8);
        rst_n = 1'b0;
        #1;
        checks++; if (digits !== 20'h0) begin failures++; $display("FAIL rstmid_digits: got %h expected 00000", digits); end
        checks++; if ({frame_valid, result, result_ok, invalid, stall, bad_an} !== 11'h0) begin failures++; $display("FAIL rstmid_outputs: got %h expected 000", {frame_valid, result, result_ok, invalid, stall, bad_an}); end
        @(negedge clk);
        rst_n = 1'b1;
        fv0 = fv_cnt;
        digit(1, 5'h00, DWELL);
        digit(2, 5'h04, DWELL);
        digit(3, 5'h0E, DWELL);
        checks++; if (fv_cnt - fv0 != 0) begin failures++; $display("FAIL rstmid_no_early_frame: got %0d expected 0", fv_cnt - fv0); end
        digit(0, 5'h04, DWELL);
        checks++; if (fv_cnt - fv0 != 1) begin failures++; $display("FAIL rstmid_frames: got %0d expected 1", fv_cnt - fv0); end
        checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL rstmid_invalid: got %b expected 1", invalid); end
    endtask

    initial begin
        bus.an = 4'hF;
        bus.seg = 7'h7F;
        @(negedge clk);
        test_reset();
        test_dash_2b();
        test_e404();
        test_glitch();
        test_bad_an();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
